seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- N_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles each digit is driven; legal range >= 2.
- ACTIVE_LOW, 1, 1 = segment, dp and anode outputs are active-low; 0 = active-high.
- HEX_MODE, 0, 1 = codes 10..15 display A,b,C,d,E,F; 0 = codes 10..15 display blank.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock, rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- enable, in, 1, 1 = scanning runs; 0 = display dark, counters hold.
- digits, in, 4*N_DIGITS, BCD/hex codes; digit i is bits [4i+3:4i]; digit 0 is the rightmost digit.
- dp, in, N_DIGITS, decimal-point request per digit.
- lz_blank, in, 1, 1 = leading-zero blanking is on.
- segment, out, 7, segment drive, bit order gfedcba (bit 0 = a).
- dp_out, out, 1, decimal-point drive.
- anode, out, N_DIGITS, one-hot digit enable.
- frame_tick, out, 1, one-cycle pulse at each frame wrap.

Function
REQ-003 The design SHALL have a refresh counter cnt that counts 0..REFRESH_DIV-1 while enable=1 and wraps to 0 after REFRESH_DIV-1.
REQ-004 A digit index idx SHALL advance by 1 on each cnt wrap and SHALL wrap from N_DIGITS-1 to 0.
REQ-005 frame_tick SHALL be 1 for exactly the cycle after idx wraps N_DIGITS-1 -> 0, registered.
REQ-006 digits, dp and lz_blank SHALL be captured into a snapshot on every enabled cycle with cnt=0 and idx=0; all display outputs SHALL derive only from the snapshot (no tearing within a frame).
REQ-007 Outputs SHALL be registered and SHALL reflect (idx, snapshot) of the previous clock cycle, giving 1-cycle latency.
REQ-008 anode SHALL be one-hot at bit idx; all other bits SHALL be inactive.
REQ-009 The segment decode (active-high form, gfedcba) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-010 When HEX_MODE=1, the decode SHALL also be: A=77, b=7C, C=39, d=5E, E=79, F=71. When HEX_MODE=0, codes 10..15 SHALL decode to 00.
REQ-011 Leading-zero blanking: with the snapshot lz_blank=1, digit i>0 SHALL be blanked (segment all off) when it and every higher digit are 0. Digit 0 SHALL never be blanked.
REQ-012 dp_out SHALL follow snapshot dp[idx] even for a blanked digit.
REQ-013 When ACTIVE_LOW=1, segment, dp_out and anode SHALL be bitwise inverted relative to the active-high form.
REQ-014 enable=0 SHALL:
- hold cnt, idx and the snapshot;
- drive all anodes, segments and dp_out inactive from the next cycle;
- force frame_tick to 0.
REQ-015 After enable rises, scanning SHALL resume from the held cnt and idx.
REQ-016 When N_DIGITS=1, idx SHALL stay 0 and frame_tick SHALL pulse on every cnt wrap.

Reset
REQ-017 rst_n=0 SHALL asynchronously force the following, holding while low:
- cnt=0, idx=0, snapshot=0;
- anode, segment and dp_out inactive (all 1 when ACTIVE_LOW=1);
- frame_tick=0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame. The first enabled cycle after release SHALL load a new snapshot (cnt=0, idx=0).

Structure
REQ-019 Package seg7_pkg SHALL hold the 16-entry gfedcba constant table, the blank pattern, and the decode function with a hex-enable argument.
REQ-020 One combinational sub-module, seg7_decode (4-bit code, hex_en, blank -> 7-bit active-high pattern), SHALL be instantiated once. Polarity inversion SHALL be applied at the output registers.

Verification
REQ-021 The bench SHALL cover these directed scenarios, each with N_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated otherwise.
- Reset release, enable=1, digits=16'h1234 -> first output cycle gives anode=4'b1110 and segment=~7'h66. Each digit holds for 4 cycles. Order: digit 0,1,2,3.
- digits=16'h0070, lz_blank=1 -> digits 3 and 2 blanked (segment=7'h7F); digit 1 shows ~07; digit 0 shows ~3F.
- digits changed to 16'h9999 mid-frame -> the current frame still shows the old value. 9 (~6F) appears only after the frame_tick.
- HEX_MODE=0 vs 1 with digit code 4'hB -> segment ~00 vs ~7C.
- enable=0 for 10 cycles mid-digit-2 -> anode=4'b1111 and frame_tick stays 0. On re-enable, digit 2 resumes with its remaining cycles.
- rst_n pulsed low for 1 cycle mid-frame -> outputs go inactive immediately (asynchronous). The next frame starts at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and decode helper.
// Patterns are active-high, bit order gfedcba.
package seg7_pkg;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] code,
    input logic       hex_en
  );
    if (!hex_en && code > 4'd9)
      return SEG_BLANK;
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder.
// Produces the active-high gfedcba pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  input  logic       blank,
  output logic [6:0] pattern
);

  // blanking overrides the table lookup
  always_comb begin
    pattern = blank ? SEG_BLANK
                    : seg_decode(code, hex_en);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver.
// One digit per REFRESH_DIV cycles, frame-coherent snapshot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  parameter int HEX_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lz_blank,
  output logic [6:0]            segment,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_tick
);

  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX =
    IW'(N_DIGITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic HEX = (HEX_MODE != 0);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic                  snap_lz;

  logic                  load;
  logic                  cnt_wrap;
  logic                  idx_wrap;
  logic [4*N_DIGITS-1:0] cur_digits;
  logic [N_DIGITS-1:0]   cur_dp;
  logic                  cur_lz;
  logic [3:0]            code;
  logic                  nz;
  logic                  blank;
  logic [6:0]            pattern;
  logic [N_DIGITS-1:0]   onehot;

  // the snapshot being loaded this cycle is already the frame's data
  always_comb begin
    load       = enable && cnt == '0 && idx == '0;
    cnt_wrap   = cnt == CNT_MAX;
    idx_wrap   = cnt_wrap && idx == IDX_MAX;
    cur_digits = load ? digits : snap_digits;
    cur_dp     = load ? dp : snap_dp;
    cur_lz     = load ? lz_blank : snap_lz;
    code       = cur_digits[{idx, 2'b00} +: 4];
    nz         = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (j >= int'(idx) &&
          cur_digits[4*j +: 4] != 4'h0)
        nz = 1'b1;
    end
    blank  = cur_lz && idx != '0 && !nz;
    onehot = N_DIGITS'(1) << idx;
  end

  seg7_decode u_decode (
    .code    (code),
    .hex_en  (HEX),
    .blank   (blank),
    .pattern (pattern)
  );

  // refresh counter and digit index, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap)
        idx <= idx_wrap ? '0 : idx + 1'b1;
    end
  end

  // frame snapshot taken at the first cycle of each frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
    end else if (load) begin
      snap_digits <= digits;
      snap_dp     <= dp;
      snap_lz     <= lz_blank;
    end
  end

  // registered drive with polarity applied here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment    <= {7{INV}};
      dp_out     <= INV;
      anode      <= {N_DIGITS{INV}};
      frame_tick <= 1'b0;
    end else if (!enable) begin
      segment    <= {7{INV}};
      dp_out     <= INV;
      anode      <= {N_DIGITS{INV}};
      frame_tick <= 1'b0;
    end else begin
      segment    <= pattern ^ {7{INV}};
      dp_out     <= cur_dp[idx] ^ INV;
      anode      <= onehot ^ {N_DIGITS{INV}};
      frame_tick <= idx_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver.
// Two instances differ only in HEX_MODE.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;

  logic [6:0]  segment, segment_hex;
  logic        dp_out, dp_out_hex;
  logic [3:0]  anode, anode_hex;
  logic        frame_tick, frame_tick_hex;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS(4), .REFRESH_DIV(4),
    .ACTIVE_LOW(1), .HEX_MODE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .digits(digits), .dp(dp), .lz_blank(lz_blank),
    .segment(segment), .dp_out(dp_out),
    .anode(anode), .frame_tick(frame_tick)
  );

  seg7_scan_driver #(
    .N_DIGITS(4), .REFRESH_DIV(4),
    .ACTIVE_LOW(1), .HEX_MODE(1)
  ) dut_hex (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .digits(digits), .dp(dp), .lz_blank(lz_blank),
    .segment(segment_hex), .dp_out(dp_out_hex),
    .anode(anode_hex), .frame_tick(frame_tick_hex)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (anode !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset anode got %b want 1111", anode);
    end
    n_checks++;
    if (segment !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset segment got %h want 7f", segment);
    end
    n_checks++;
    if (dp_out !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset dp/tick got %b%b want 10",
               dp_out, frame_tick);
    end
  endtask

  task automatic test_scan();
    logic [3:0]  one = 4'b0001;
    logic [15:0] val = 16'h1234;
    logic [3:0]  ea;
    logic [6:0]  es;
    int d;
    digits   = val;
    dp       = 4'b0010;
    lz_blank = 1'b0;
    enable   = 1'b1;
    rst_n    = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      es = ~dec(val[4*d +: 4]);
      n_checks++;
      if (anode !== ea) begin
        n_fail++;
        $display("FAIL scan anode k=%0d got %b want %b",
                 k, anode, ea);
      end
      n_checks++;
      if (segment !== es) begin
        n_fail++;
        $display("FAIL scan segment k=%0d got %h want %h",
                 k, segment, es);
      end
      n_checks++;
      if (dp_out !== ~dp[d]) begin
        n_fail++;
        $display("FAIL scan dp k=%0d got %b want %b",
                 k, dp_out, ~dp[d]);
      end
      n_checks++;
      if (frame_tick !== (k == 16)) begin
        n_fail++;
        $display("FAIL scan tick k=%0d got %b want %b",
                 k, frame_tick, (k == 16));
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] one = 4'b0001;
    logic [3:0] ea;
    logic [6:0] es;
    int d;
    digits   = 16'h0070;
    dp       = 4'b0100;
    lz_blank = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      case (d)
        0: es = ~7'h3F;
        1: es = ~7'h07;
        default: es = 7'h7F;
      endcase
      n_checks++;
      if (anode !== ea || segment !== es) begin
        n_fail++;
        $display("FAIL lz k=%0d got %b/%h want %b/%h",
                 k, anode, segment, ea, es);
      end
      n_checks++;
      if (dp_out !== ~dp[d]) begin
        n_fail++;
        $display("FAIL lz dp k=%0d got %b want %b",
                 k, dp_out, ~dp[d]);
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [3:0]  one = 4'b0001;
    logic [15:0] old = 16'h1234;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        et;
    int d;
    digits   = old;
    dp       = 4'b0000;
    lz_blank = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      d  = ((k - 1) / 4) % 4;
      ea = ~(one << d);
      es = (k <= 16) ? ~dec(old[4*d +: 4]) : ~7'h6F;
      et = (k == 16) || (k == 32);
      n_checks++;
      if (anode !== ea || segment !== es) begin
        n_fail++;
        $display("FAIL tear k=%0d got %b/%h want %b/%h",
                 k, anode, segment, ea, es);
      end
      n_checks++;
      if (frame_tick !== et) begin
        n_fail++;
        $display("FAIL tear tick k=%0d got %b want %b",
                 k, frame_tick, et);
      end
      if (k == 6)
        digits = 16'h9999;
    end
  endtask

  task automatic test_hex_mode();
    logic [3:0] one = 4'b0001;
    logic [3:0] ea;
    int d;
    digits = 16'hBBBB;
    for (int k = 1; k <= 16; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      n_checks++;
      if (segment !== 7'h7F || anode !== ea) begin
        n_fail++;
        $display("FAIL hex0 k=%0d got %h/%b want 7f/%b",
                 k, segment, anode, ea);
      end
      n_checks++;
      if (segment_hex !== 7'h03 || anode_hex !== ea) begin
        n_fail++;
        $display("FAIL hex1 k=%0d got %h/%b want 03/%b",
                 k, segment_hex, anode_hex, ea);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0]  one = 4'b0001;
    logic [15:0] val = 16'h1234;
    logic [3:0]  ea;
    logic [6:0]  es;
    int d;
    digits = val;
    for (int k = 1; k <= 10; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      es = ~dec(val[4*d +: 4]);
      n_checks++;
      if (anode !== ea || segment !== es) begin
        n_fail++;
        $display("FAIL en_pre k=%0d got %b/%h want %b/%h",
                 k, anode, segment, ea, es);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (anode !== 4'b1111 || segment !== 7'h7F ||
          dp_out !== 1'b1 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL en_off c=%0d got %b/%h/%b/%b want 1111/7f/1/0",
                 k, anode, segment, dp_out, frame_tick);
      end
    end
    enable = 1'b1;
    for (int k = 11; k <= 16; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      es = ~dec(val[4*d +: 4]);
      n_checks++;
      if (anode !== ea || segment !== es) begin
        n_fail++;
        $display("FAIL en_resume k=%0d got %b/%h want %b/%h",
                 k, anode, segment, ea, es);
      end
      n_checks++;
      if (frame_tick !== (k == 16)) begin
        n_fail++;
        $display("FAIL en_resume tick k=%0d got %b want %b",
                 k, frame_tick, (k == 16));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] one = 4'b0001;
    logic [3:0] ea;
    logic [6:0] es;
    int d;
    digits = 16'h1234;
    repeat (5) tick();
    n_checks++;
    if (anode !== 4'b1101) begin
      n_fail++;
      $display("FAIL rst_mid pre anode got %b want 1101", anode);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (anode !== 4'b1111 || segment !== 7'h7F ||
        dp_out !== 1'b1 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid async got %b/%h/%b/%b want 1111/7f/1/0",
               anode, segment, dp_out, frame_tick);
    end
    digits = 16'h5678;
    tick();
    n_checks++;
    if (anode !== 4'b1111 || segment !== 7'h7F) begin
      n_fail++;
      $display("FAIL rst_mid hold got %b/%h want 1111/7f",
               anode, segment);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      d  = (k - 1) / 4;
      ea = ~(one << d);
      es = (d == 0) ? ~7'h7F : ~7'h07;
      n_checks++;
      if (anode !== ea || segment !== es) begin
        n_fail++;
        $display("FAIL rst_mid after k=%0d got %b/%h want %b/%h",
                 k, anode, segment, ea, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_no_tearing();
    test_hex_mode();
    test_enable_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
